// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: run-control FSM, hazard stall/flush generation, operand
// forwarding selects and saturating performance counters for a 5-stage pipe.
module pipeline_ctrl #(
  parameter int REG_ADDR_W    = 5,
  parameter int CNT_W         = 32,
  parameter int FLUSH_DEPTH   = 3,
  parameter bit LOAD_USE_ONLY = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  // run control
  input  logic                  start,
  input  logic                  resume,
  input  logic                  step_req,
  input  logic                  halt_req,
  input  logic                  ext_stall,
  input  logic                  clear_counters,
  // decode-stage sources
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  // EX-stage destination
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  // EX-stage sources and later-stage destinations
  input  logic [REG_ADDR_W-1:0] rs1_ex,
  input  logic [REG_ADDR_W-1:0] rs2_ex,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  wb_valid,
  input  logic                  branch_taken_mem,
  // status and pipeline control
  output logic [1:0]            state,
  output logic                  run,
  output logic                  freeze_all,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic                  flush_mem,
  output logic [1:0]            fwd_sel_1,
  output logic [1:0]            fwd_sel_2,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      retired_count,
  output logic [CNT_W-1:0]      stall_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10,
    S_STEP = 2'b11
  } state_t;

  // Forwarding select encodings
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // How deep a taken branch squashes, fixed at elaboration
  localparam logic P_FLUSH_EX  = (FLUSH_DEPTH >= 2);
  localparam logic P_FLUSH_MEM = (FLUSH_DEPTH >= 3);

  state_t           r_state;
  state_t           w_state_nxt;

  logic             w_run;
  logic             w_freeze;
  logic             w_rs1_match;
  logic             w_rs2_match;
  logic             w_hazard;

  logic             w_stall;
  logic             w_flush_id;
  logic             w_flush_ex;
  logic             w_flush_mem;

  logic [1:0]       w_fwd_1;
  logic [1:0]       w_fwd_2;

  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_retired_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_cycle_inc;
  logic             w_retired_inc;
  logic             w_stall_inc;

  // Run-control state register; reset returns to IDLE from any state
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: resume beats step_req in HALT, STEP lasts one cycle
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start)    w_state_nxt = S_RUN;
      S_RUN:  if (halt_req) w_state_nxt = S_HALT;
      S_HALT: begin
        if (resume)        w_state_nxt = S_RUN;
        else if (step_req) w_state_nxt = S_STEP;
      end
      S_STEP: w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Run/freeze status and the decode-vs-EX data hazard
  always_comb begin
    w_run       = (r_state == S_RUN) || (r_state == S_STEP);
    w_freeze    = ext_stall || !w_run;
    w_rs1_match = rs1_used && (rs1_id == ex_rd);
    w_rs2_match = rs2_used && (rs2_id == ex_rd);
    w_hazard    = ex_reg_write && (ex_rd != '0) && (w_rs1_match || w_rs2_match)
                  && (!LOAD_USE_ONLY || ex_mem_read);
  end

  // Stall/flush priority: freeze, then taken branch, then hazard bubble
  always_comb begin
    w_stall     = 1'b0;
    w_flush_id  = 1'b0;
    w_flush_ex  = 1'b0;
    w_flush_mem = 1'b0;
    if (w_freeze) begin
      w_stall = 1'b1;
    end else if (branch_taken_mem) begin
      w_flush_id  = 1'b1;
      w_flush_ex  = P_FLUSH_EX;
      w_flush_mem = P_FLUSH_MEM;
    end else if (w_hazard) begin
      w_stall    = 1'b1;
      w_flush_ex = 1'b1;
    end
  end

  // Operand forwarding; the younger MEM result wins over WB, x0 never forwards
  always_comb begin
    w_fwd_1 = FWD_RF;
    w_fwd_2 = FWD_RF;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs1_ex))
      w_fwd_1 = FWD_MEM;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs1_ex))
      w_fwd_1 = FWD_WB;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs2_ex))
      w_fwd_2 = FWD_MEM;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs2_ex))
      w_fwd_2 = FWD_WB;
  end

  // Counter increment conditions
  always_comb begin
    w_cycle_inc   = w_run;
    w_retired_inc = wb_valid && !w_freeze;
    w_stall_inc   = w_run && (ext_stall || w_stall);
  end

  // Saturating performance counters; reset and clear both zero them
  always_ff @(posedge sys_clk) begin
    if (rst || clear_counters) begin
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
      r_stall_cnt   <= '0;
    end else begin
      if (w_cycle_inc && (r_cycle_cnt != '1))
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_retired_inc && (r_retired_cnt != '1))
        r_retired_cnt <= r_retired_cnt + CNT_W'(1);
      if (w_stall_inc && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign state         = r_state;
  assign run           = w_run;
  assign freeze_all    = w_freeze;
  assign stall_if      = w_stall;
  assign stall_id      = w_stall;
  assign flush_id      = w_flush_id;
  assign flush_ex      = w_flush_ex;
  assign flush_mem     = w_flush_mem;
  assign fwd_sel_1     = w_fwd_1;
  assign fwd_sel_2     = w_fwd_2;
  assign cycle_count   = r_cycle_cnt;
  assign retired_count = r_retired_cnt;
  assign stall_count   = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: two pipeline_ctrl configurations driven by shared inputs
// and compared every cycle against a behavioural model of the control rules.
module tb_pipeline_ctrl;

  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, resume, step_req, halt_req, ext_stall, clear_counters;
  logic [AW-1:0] rs1_id, rs2_id, ex_rd, rs1_ex, rs2_ex, mem_rd, wb_rd;
  logic          rs1_used, rs2_used, ex_reg_write, ex_mem_read;
  logic          mem_reg_write, wb_reg_write, wb_valid, branch_taken_mem;

  // Config A: defaults (CNT_W=32, FLUSH_DEPTH=3, LOAD_USE_ONLY=1)
  logic [1:0]  a_state, a_fwd1, a_fwd2;
  logic        a_run, a_frz, a_sif, a_sid, a_fid, a_fex, a_fmem;
  logic [31:0] a_cyc, a_ret, a_stl;
  // Config B: CNT_W=4, FLUSH_DEPTH=1, LOAD_USE_ONLY=0
  logic [1:0]  b_state, b_fwd1, b_fwd2;
  logic        b_run, b_frz, b_sif, b_sid, b_fid, b_fex, b_fmem;
  logic [3:0]  b_cyc, b_ret, b_stl;

  pipeline_ctrl dut_a (
    .sys_clk(clk), .rst(rst), .start(start), .resume(resume), .step_req(step_req),
    .halt_req(halt_req), .ext_stall(ext_stall), .clear_counters(clear_counters),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_valid(wb_valid),
    .branch_taken_mem(branch_taken_mem),
    .state(a_state), .run(a_run), .freeze_all(a_frz), .stall_if(a_sif), .stall_id(a_sid),
    .flush_id(a_fid), .flush_ex(a_fex), .flush_mem(a_fmem),
    .fwd_sel_1(a_fwd1), .fwd_sel_2(a_fwd2),
    .cycle_count(a_cyc), .retired_count(a_ret), .stall_count(a_stl)
  );

  pipeline_ctrl #(.REG_ADDR_W(AW), .CNT_W(4), .FLUSH_DEPTH(1), .LOAD_USE_ONLY(1'b0)) dut_b (
    .sys_clk(clk), .rst(rst), .start(start), .resume(resume), .step_req(step_req),
    .halt_req(halt_req), .ext_stall(ext_stall), .clear_counters(clear_counters),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_valid(wb_valid),
    .branch_taken_mem(branch_taken_mem),
    .state(b_state), .run(b_run), .freeze_all(b_frz), .stall_if(b_sif), .stall_id(b_sid),
    .flush_id(b_fid), .flush_ex(b_fex), .flush_mem(b_fmem),
    .fwd_sel_1(b_fwd1), .fwd_sel_2(b_fwd2),
    .cycle_count(b_cyc), .retired_count(b_ret), .stall_count(b_stl)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: state as a number 0..3, counters as plain integers
  int              m_state;
  longint unsigned ca[3];
  longint unsigned cb[3];
  localparam longint unsigned MAX_A = 64'hFFFF_FFFF;
  localparam longint unsigned MAX_B = 64'd15;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit hazard(input bit lu_only);
    bit m;
    m = (rs1_used && rs1_id == ex_rd) || (rs2_used && rs2_id == ex_rd);
    return ex_reg_write && ex_rd != 0 && m && (!lu_only || ex_mem_read);
  endfunction

  function automatic int fwd(input logic [AW-1:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 1;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2;
    return 0;
  endfunction

  task automatic exp_ctrl(input bit frz, input bit lu_only, input int depth,
                          output bit st, output bit fid, output bit fex, output bit fmem);
    st = 0; fid = 0; fex = 0; fmem = 0;
    if (frz) st = 1;
    else if (branch_taken_mem) begin
      fid = 1; fex = (depth >= 2); fmem = (depth >= 3);
    end else if (hazard(lu_only)) begin
      st = 1; fex = 1;
    end
  endtask

  function automatic longint unsigned bump(input longint unsigned v, input bit inc,
                                           input longint unsigned mx);
    return (inc && v < mx) ? v + 1 : v;
  endfunction

  // Check all outputs against the model, then advance model and clock one cycle
  task automatic step(input bit chk);
    bit r, fz, sta, fida, fexa, fmema, stb, fidb, fexb, fmemb;
    int ns;
    #1;
    r  = (m_state == 1) || (m_state == 3);
    fz = ext_stall || !r;
    exp_ctrl(fz, 1'b1, 3, sta, fida, fexa, fmema);
    exp_ctrl(fz, 1'b0, 1, stb, fidb, fexb, fmemb);
    if (chk) begin
      check("a_state", 64'(a_state), 64'(m_state));
      check("a_run",   64'(a_run),   64'(r));
      check("a_frz",   64'(a_frz),   64'(fz));
      check("a_sif",   64'(a_sif),   64'(sta));
      check("a_sid",   64'(a_sid),   64'(sta));
      check("a_fid",   64'(a_fid),   64'(fida));
      check("a_fex",   64'(a_fex),   64'(fexa));
      check("a_fmem",  64'(a_fmem),  64'(fmema));
      check("a_fwd1",  64'(a_fwd1),  64'(fwd(rs1_ex)));
      check("a_fwd2",  64'(a_fwd2),  64'(fwd(rs2_ex)));
      check("a_cyc",   64'(a_cyc),   ca[0]);
      check("a_ret",   64'(a_ret),   ca[1]);
      check("a_stl",   64'(a_stl),   ca[2]);
      check("b_state", 64'(b_state), 64'(m_state));
      check("b_sid",   64'(b_sid),   64'(stb));
      check("b_sif",   64'(b_sif),   64'(stb));
      check("b_fid",   64'(b_fid),   64'(fidb));
      check("b_fex",   64'(b_fex),   64'(fexb));
      check("b_fmem",  64'(b_fmem),  64'(fmemb));
      check("b_cyc",   64'(b_cyc),   cb[0]);
      check("b_ret",   64'(b_ret),   cb[1]);
      check("b_stl",   64'(b_stl),   cb[2]);
    end
    case (m_state)
      0: ns = start ? 1 : 0;
      1: ns = halt_req ? 2 : 1;
      2: ns = resume ? 1 : (step_req ? 3 : 2);
      default: ns = 2;
    endcase
    if (rst) ns = 0;
    if (rst || clear_counters) begin
      ca = '{0, 0, 0};
      cb = '{0, 0, 0};
    end else begin
      ca[0] = bump(ca[0], r, MAX_A);
      ca[1] = bump(ca[1], wb_valid && !fz, MAX_A);
      ca[2] = bump(ca[2], r && (ext_stall || sta), MAX_A);
      cb[0] = bump(cb[0], r, MAX_B);
      cb[1] = bump(cb[1], wb_valid && !fz, MAX_B);
      cb[2] = bump(cb[2], r && (ext_stall || stb), MAX_B);
    end
    m_state = ns;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; start = 0; resume = 0; step_req = 0; halt_req = 0; ext_stall = 0;
    clear_counters = 0; rs1_id = '0; rs2_id = '0; rs1_used = 0; rs2_used = 0;
    ex_rd = '0; ex_reg_write = 0; ex_mem_read = 0; rs1_ex = '0; rs2_ex = '0;
    mem_rd = '0; mem_reg_write = 0; wb_rd = '0; wb_reg_write = 0; wb_valid = 0;
    branch_taken_mem = 0;
  endtask

  logic [31:0] ret0;

  initial begin
    m_state = 0;
    ca = '{0, 0, 0};
    cb = '{0, 0, 0};
    idle();
    @(negedge clk);
    // cycles 0,1 reset, start pulsed in cycle 2
    rst = 1; step(0);
    rst = 1; step(1);
    rst = 0;
    #1;
    check("rst_run",   64'(a_run), 64'd0);
    check("rst_frz",   64'(a_frz), 64'd1);
    check("rst_stall", 64'(a_sif), 64'd1);
    check("rst_flush", 64'({a_fid, a_fex, a_fmem}), 64'd0);
    start = 1; step(1);
    start = 0;
    #1;
    check("start_state", 64'(a_state), 64'd1);
    check("start_run",   64'(a_run),   64'd1);
    for (int i = 0; i < 5; i++) step(1);
    #1;
    check("cyc_after5", 64'(a_cyc), 64'd5);

    // load-use hazard, then plain write match
    ex_reg_write = 1; ex_mem_read = 1; ex_rd = 5; rs1_id = 5; rs1_used = 1;
    #1;
    check("lu_stall", 64'({a_sif, a_sid, a_fex}), 64'b111);
    step(1);
    ex_mem_read = 0;
    #1;
    check("nolu_a", 64'({a_sif, a_sid, a_fex}), 64'b000);
    check("nolu_b", 64'({b_sif, b_sid}), 64'b11);
    step(1);

    // taken branch overrides hazard
    ex_mem_read = 1; branch_taken_mem = 1;
    #1;
    check("br_a", 64'({a_sid, a_fid, a_fex, a_fmem}), 64'b0111);
    check("br_b", 64'({b_sid, b_fid, b_fex, b_fmem}), 64'b0100);
    step(1);
    idle();

    // forwarding priority and x0
    mem_reg_write = 1; wb_reg_write = 1; mem_rd = 7; wb_rd = 7; rs2_ex = 7;
    #1;
    check("fwd_mem_wins", 64'(a_fwd2), 64'd1);
    step(1);
    mem_rd = 0; rs2_ex = 0;
    #1;
    check("fwd_x0", 64'(a_fwd2), 64'd0);
    step(1);
    idle();

    // halt, single step with a retiring instruction, back to halt
    halt_req = 1; step(1);
    halt_req = 0;
    #1;
    check("halt_state", 64'(a_state), 64'd2);
    ret0 = a_ret;
    step_req = 1; step(1);
    step_req = 0; wb_valid = 1;
    #1;
    check("step_state", 64'(a_state), 64'd3);
    step(1);
    #1;
    check("back_halt", 64'(a_state), 64'd2);
    step(1);
    wb_valid = 0;
    #1;
    check("step_retire", 64'(a_ret), 64'(ret0 + 1));

    // saturation of the narrow counters, clear and mid-run reset
    resume = 1; step(1);
    resume = 0;
    for (int i = 0; i < 20; i++) step(1);
    #1;
    check("b_cyc_sat", 64'(b_cyc), 64'd15);
    clear_counters = 1; step(1);
    clear_counters = 0;
    #1;
    check("clr_a", 64'(a_cyc), 64'd0);
    check("clr_b", 64'(b_cyc), 64'd0);
    check("clr_state", 64'(a_state), 64'd1);
    rst = 1; step(1);
    rst = 0;
    #1;
    check("midrun_rst", 64'(a_state), 64'd0);

    // randomized stimulus
    for (int i = 0; i < 4000; i++) begin
      rst              = ($urandom_range(0, 199) == 0);
      start            = ($urandom_range(0, 7) == 0);
      resume           = ($urandom_range(0, 7) == 0);
      step_req         = ($urandom_range(0, 5) == 0);
      halt_req         = ($urandom_range(0, 15) == 0);
      ext_stall        = ($urandom_range(0, 3) == 0);
      clear_counters   = ($urandom_range(0, 99) == 0);
      rs1_id           = AW'($urandom_range(0, 7));
      rs2_id           = AW'($urandom_range(0, 7));
      rs1_used         = 1'($urandom);
      rs2_used         = 1'($urandom);
      ex_rd            = AW'($urandom_range(0, 7));
      ex_reg_write     = 1'($urandom);
      ex_mem_read      = 1'($urandom);
      rs1_ex           = AW'($urandom_range(0, 7));
      rs2_ex           = AW'($urandom_range(0, 7));
      mem_rd           = AW'($urandom_range(0, 7));
      mem_reg_write    = 1'($urandom);
      wb_rd            = AW'($urandom_range(0, 7));
      wb_reg_write     = 1'($urandom);
      wb_valid         = 1'($urandom);
      branch_taken_mem = ($urandom_range(0, 4) == 0);
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
